// File: rtl/lfsr_sequencer.sv
// WIDTH-bit LFSR with Fibonacci/Galois feedback, lockup-safe seed load,
// single-step advance and counted bursts under a start/busy/done handshake.
module lfsr_sequencer #(
  parameter int unsigned           WIDTH    = 8,
  parameter logic [WIDTH-1:0]      FIB_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0]      GAL_MASK = 8'h1D,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  input  logic             enable,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] SeedOne = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             do_step;
  logic             step_mode;
  logic [WIDTH-1:0] step_next;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur,
                                                 input logic             gal);
    logic [WIDTH-1:0] shifted;
    shifted = {cur[WIDTH-2:0], 1'b0};
    if (gal) begin
      lfsr_next = cur[WIDTH-1] ? (shifted ^ GAL_MASK) : shifted;
    end else begin
      lfsr_next = {cur[WIDTH-2:0], ^(cur & FIB_TAPS)};
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    out_d     = out_q;
    seed_d    = seed_q;
    done_d    = 1'b0;
    wrap_d    = wrap_q;
    do_step   = 1'b0;
    step_mode = mode;
    step_next = '0;

    if (load) begin
      // All-zero would lock the register, so it is replaced by 1.
      out_d   = (seed == '0) ? SeedOne : seed;
      seed_d  = (seed == '0) ? SeedOne : seed;
      wrap_d  = 1'b0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (steps == '0) begin
              done_d = 1'b1;
            end else begin
              mode_d  = mode;
              cnt_d   = steps;
              state_d = StRun;
            end
          end else if (enable) begin
            do_step = 1'b1;
          end
        end
        StRun: begin
          do_step   = 1'b1;
          step_mode = mode_q;
          if (cnt_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end

    if (do_step) begin
      step_next = lfsr_next(out_q, step_mode);
      out_d     = step_next;
      wrap_d    = (step_next == seed_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      out_q   <= SeedOne;
      seed_q  <= SeedOne;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      seed_q  <= seed_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == StRun);
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Directed self-checking bench for lfsr_sequencer (8-bit defaults).
module tb_lfsr_sequencer;

  logic        clk;
  logic        reset;
  logic        load;
  logic [7:0]  seed;
  logic        mode;
  logic        enable;
  logic        start;
  logic [15:0] steps;
  logic [7:0]  out;
  logic        busy;
  logic        done;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  lfsr_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .seed   (seed),
    .mode   (mode),
    .enable (enable),
    .start  (start),
    .steps  (steps),
    .out    (out),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fib_exp [5];

  initial begin
    fib_exp[0] = 8'h02; fib_exp[1] = 8'h04; fib_exp[2] = 8'h08;
    fib_exp[3] = 8'h11; fib_exp[4] = 8'h23;

    reset = 1'b1; load = 1'b0; seed = '0; mode = 1'b0;
    enable = 1'b0; start = 1'b0; steps = '0;
    tick();
    tick();
    check("reset_out", 32'(out), 32'h01);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    reset = 1'b0;

    // Fibonacci sequence
    load = 1'b1; seed = 8'h01; mode = 1'b0;
    tick();
    load = 1'b0;
    check("fib_load", 32'(out), 32'h01);
    check("fib_load_wrap", 32'(wrap), 32'h0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("fib_step%0d", i), 32'(out), 32'(fib_exp[i]));
    end
    enable = 1'b0;

    // Galois step and lockup guard
    load = 1'b1; seed = 8'h80;
    tick();
    load = 1'b0;
    check("gal_load", 32'(out), 32'h80);
    mode = 1'b1; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("gal_step", 32'(out), 32'h1D);
    load = 1'b1; seed = 8'h00;
    tick();
    load = 1'b0;
    check("lockup_guard", 32'(out), 32'h01);

    // Full-period burst; mode flipped mid-burst must not matter
    load = 1'b1; seed = 8'h01; mode = 1'b0;
    tick();
    load = 1'b0;
    start = 1'b1; steps = 16'd255;
    tick();
    start = 1'b0; mode = 1'b1;
    check("burst_busy_start", 32'(busy), 32'h1);
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i < 255) begin
        if (busy !== 1'b1 || done !== 1'b0 || wrap !== 1'b0) begin
          check($sformatf("burst_mid%0d", i), {29'b0, busy, done, wrap}, 32'b100);
        end else begin
          checks++;
        end
      end else begin
        check("burst_end_busy", 32'(busy), 32'h0);
        check("burst_end_done", 32'(done), 32'h1);
        check("burst_end_out", 32'(out), 32'h01);
        check("burst_end_wrap", 32'(wrap), 32'h1);
      end
    end
    tick();
    check("burst_done_pulse", 32'(done), 32'h0);
    mode = 1'b0;

    // Zero-length burst
    start = 1'b1; steps = 16'd0;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    check("zero_out", 32'(out), 32'h01);
    tick();
    check("zero_done_pulse", 32'(done), 32'h0);

    // Abort by load; enable/start during the burst are ignored
    start = 1'b1; steps = 16'd10;
    tick();
    check("abort_busy", 32'(busy), 32'h1);
    start = 1'b1; steps = 16'd0; enable = 1'b1;
    tick();
    check("abort_step1", 32'(out), 32'h02);
    check("abort_start_ignored", 32'(done), 32'h0);
    tick();
    check("abort_step2", 32'(out), 32'h04);
    check("abort_busy2", 32'(busy), 32'h1);
    start = 1'b0; enable = 1'b0;
    load = 1'b1; seed = 8'h5A;
    tick();
    load = 1'b0;
    check("abort_out", 32'(out), 32'h5A);
    check("abort_busy_clr", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || out !== 8'h5A) begin
        check($sformatf("abort_quiet%0d", i), {23'b0, done, out}, 32'h05A);
      end else begin
        checks++;
      end
    end

    // Asynchronous reset mid-burst
    start = 1'b1; steps = 16'd20;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rst_busy_before", 32'(busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_out", 32'(out), 32'h01);
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_done", 32'(done), 32'h0);
    tick();
    reset = 1'b0;
    mode = 1'b0; enable = 1'b1;
    tick();
    check("rst_resume1", 32'(out), 32'h02);
    tick();
    check("rst_resume2", 32'(out), 32'h04);
    enable = 1'b0;
    check("rst_resume_done", 32'(done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_sequencer.md
# lfsr_sequencer

Parametrised successor to the team's fixed 8-bit shift-register generator. It is a WIDTH-bit linear feedback shift register with two modes: Fibonacci XOR feedback and Galois XOR feedback. It supports seed loading with lockup protection, single-step advance, and counted bursts under a start/busy/done handshake. A wrap flag marks when the sequence returns to the loaded seed. It sits beside the processor datapath as a pseudo-random source and BIST pattern generator.

## Interface
- `WIDTH`, 8: register width, minimum 3.
- `FIB_TAPS`, 8'hB8: Fibonacci tap mask; bit i set means state[i] feeds the XOR.
- `GAL_MASK`, 8'h1D: Galois feedback mask; XORed into the shifted state when the MSB is 1.
- `CNT_W`, 16: width of the burst step count.

- `clk`  in  1  the only clock; everything updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `load`  in  1  load `seed` into the register.
- `seed`  in  WIDTH  seed value.
- `mode`  in  1  feedback mode: 0 = Fibonacci, 1 = Galois.
- `enable`  in  1  advance one step; used only when idle.
- `start`  in  1  begin a burst of `steps` advances.
- `steps`  in  CNT_W  burst length.
- `out`  out  WIDTH  current register state.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst completion.
- `wrap`  out  1  high while `out` equals the stored seed, after at least one step since the last load.

## Operation
- **Fibonacci step:** fb = ^(out & FIB_TAPS); next = {out[WIDTH-2:0], fb}.
- **Galois step:** next = {out[WIDTH-2:0], 1'b0} ^ (out[WIDTH-1] ? GAL_MASK : 0).
- **Lockup guard:** all-zero is the lockup state in both modes.
  - A `load` with `seed` = 0 stores and outputs {0…0,1}.
  - The stored seed register holds the substituted value.
- **States:** IDLE and RUN.
- **IDLE**, checked in priority order:
  - `load`: out ← seed (after guard); seed register ← same value; clear the stepped flag; wrap ← 0.
  - `start` with `steps` = 0: done ← 1; remain IDLE; no step.
  - `start` with `steps` > 0: latch `mode` and `steps`; busy ← 1; go to RUN; no step on this edge.
  - `enable`: one step using the live `mode`.
- **RUN:**
  - Each edge performs one step using the latched mode and decrements the count.
  - The edge that performs the final step also sets busy ← 0, done ← 1, state ← IDLE.
- **Priority:** `load` beats everything, in any state.
  - A `load` during RUN aborts the burst: busy ← 0, no `done` pulse, state ← IDLE, seed loaded.
- **Ignored inputs:** `start` and `enable` are ignored while busy. `mode` changes during RUN have no effect.
- **`wrap`:**
  - Registered, aligned with `out`.
  - Set to 1 on a step whose next value equals the stored seed; otherwise 0.
  - Never asserted by a `load` itself.
- **Step count:** the count decrements modulo 2^CNT_W and never underflows, because RUN exits when the count reaches 1.

## Timing
- **Reset values (async):** out = {0…0,1}; seed register = {0…0,1}; busy = 0; done = 0; wrap = 0; state = IDLE.
- **Load:** `load` sampled at edge N gives `out` = seed after edge N. Latency 1.
- **Single step:** `enable` sampled at edge N gives `out` = next(out) after edge N.
- **Burst:**
  - `start` at edge N: busy = 1 after edge N.
  - Steps occur on edges N+1 … N+S.
  - After edge N+S: busy = 0 and done = 1 for exactly one cycle.
  - A new `start` is accepted at edge N+S+1 at the earliest.
- **Back-to-back:** `start` and `load` in the same cycle → load wins; start is dropped.
- **Reset mid-burst:** all outputs return to their reset values immediately; no `done` pulse.

## Test plan
- **Fibonacci sequence:** reset, load 8'h01, mode 0, `enable` held 5 cycles → out = 02, 04, 08, 11, 23.
- **Galois step and lockup guard:**
  - load 8'h80, mode 1, one `enable` → out = 8'h1D.
  - load 8'h00 → out = 8'h01.
- **Full-period burst:** load 8'h01, `start` with `steps` = 255, mode 0.
  - busy is high for 255 cycles after the start edge.
  - After the 255th step, done pulses once, out = 8'h01, and wrap = 1 in the same cycle.
  - wrap is not asserted at any earlier cycle.
- **Zero-length burst:** `start` with `steps` = 0 → done pulses the next cycle, busy stays 0, out unchanged.
- **Abort:** `start` with `steps` = 10; `load` 8'h5A asserted 3 cycles later.
  - out = 5A; busy = 0; no done pulse.
  - `enable` and `start` asserted during the burst before the abort are confirmed ignored.
- **Async reset mid-burst:** `reset` asserted between edges during RUN.
  - out = 8'h01 and busy = 0 immediately, without waiting for a clock edge.
  - After release, `enable` resumes stepping from 8'h01.
